// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one adder/parity unit among NREQ requesters.
// The granted sum is held in a single-entry result slot drained by a valid/ready consumer.
module adder_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_parity,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [CNTW-1:0]           txn_count
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             par_q, par_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0]   grant;
  logic [IDW:0]     idx_w;
  logic             any_valid;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sum_new;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant     = ptr_q;
    any_valid = 1'b0;
    idx_w     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NREQ)) begin
        idx_w = idx_w - (IDW+1)'(NREQ);
      end
      if (req_valid[idx_w[IDW-1:0]]) begin
        grant     = idx_w[IDW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign slot_free = (state_q == EMPTY) | rsp_ready;
  assign accept    = any_valid & slot_free & ~rst;
  assign sum_new   = a_arr[grant] + b_arr[grant];

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    par_d   = par_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      sum_d   = sum_new;
      par_d   = ^sum_new;
      id_d    = grant;
      ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      par_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      par_q   <= par_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_sum    = sum_q;
  assign rsp_parity = par_q;
  assign rsp_id     = id_q;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Cycle table plus scoreboard for adder_rr_arbiter; a narrow counter makes saturation reachable.
module tb_adder_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam logic [31:0] A_RR = 32'h03020100;
  localparam logic [31:0] B_RR = 32'h10101010;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_parity;
  logic [1:0]  rsp_id;
  logic [3:0]  txn_count;

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_parity (rsp_parity),
    .rsp_id     (rsp_id),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [3:0]  er;
    logic        ev;
    logic        push;
    logic [7:0]  psum;
    logic        ppar;
    logic [1:0]  pid;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       par;
    logic [1:0] id;
  } exp_t;

  vec_t vecs [34];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_exp = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic do_cycle(input vec_t v);
    exp_t e;
    rst       = v.rst;
    req_valid = v.vld;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = v.rdy;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(v.er));
    chk("rsp_valid", 32'(rsp_valid), 32'(v.ev));
    chk("txn_count", 32'(txn_count), 32'(cnt_exp));
    if (v.ev) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        chk("rsp_sum", 32'(rsp_sum), 32'(sb[0].sum));
        chk("rsp_parity", 32'(rsp_parity), 32'(sb[0].par));
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      end
    end
    if (v.zero) begin
      chk("zero_sum", 32'(rsp_sum), 32'd0);
      chk("zero_parity", 32'(rsp_parity), 32'd0);
      chk("zero_id", 32'(rsp_id), 32'd0);
    end
    $display("cyc rst=%b vld=%b rdy=%b -> req_ready=%b rsp_valid=%b sum=%h par=%b id=%0d cnt=%0d",
             v.rst, v.vld, v.rdy, req_ready, rsp_valid, rsp_sum, rsp_parity, rsp_id, txn_count);
    @(posedge clk);
    #1;
    if (v.rst) begin
      sb.delete();
      cnt_exp = 0;
    end else begin
      if (v.ev && v.rdy && sb.size() > 0) void'(sb.pop_front());
      if (v.push) begin
        e.sum = v.psum;
        e.par = v.ppar;
        e.id  = v.pid;
        sb.push_back(e);
        if (cnt_exp < 15) cnt_exp++;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] par_lut;
    vecs[0]  = '{1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'h4, 32'h00FF0000, 32'h00020000, 1'b1, 4'h4, 1'b0, 1'b1, 8'h01, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, A_RR, B_RR, 1'b1, 4'h1, 1'b0, 1'b1, 8'h10, 1'b1, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 4'hF, A_RR, B_RR, 1'b1, 4'h2, 1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, A_RR, B_RR, 1'b1, 4'h4, 1'b1, 1'b1, 8'h12, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'hF, A_RR, B_RR, 1'b1, 4'h8, 1'b1, 1'b1, 8'h13, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{1'b0, 4'hF, A_RR, B_RR, 1'b1, 4'h1, 1'b1, 1'b1, 8'h10, 1'b1, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 4'h4, 32'h00050000, 32'h00050000, 1'b0, 4'h4, 1'b0, 1'b1, 8'h0A, 1'b0, 2'd2, 1'b0};
    vecs[15] = '{1'b0, 4'h2, 32'h00002000, 32'h00002200, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 4'h2, 32'h00002000, 32'h00002200, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 4'h2, 32'h00002000, 32'h00002200, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 4'h2, 32'h00002000, 32'h00002200, 1'b1, 4'h2, 1'b1, 1'b1, 8'h42, 1'b0, 2'd1, 1'b0};
    vecs[19] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[21] = '{1'b0, 4'hA, 32'h7F000100, 32'h01000100, 1'b1, 4'h8, 1'b0, 1'b1, 8'h80, 1'b1, 2'd3, 1'b0};
    vecs[22] = '{1'b0, 4'h2, 32'h7F000100, 32'h01000100, 1'b1, 4'h2, 1'b1, 1'b1, 8'h02, 1'b1, 2'd1, 1'b0};
    vecs[23] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[24] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[25] = '{1'b0, 4'hF, A_RR, B_RR, 1'b0, 4'h4, 1'b0, 1'b1, 8'h12, 1'b0, 2'd2, 1'b0};
    vecs[26] = '{1'b0, 4'hB, A_RR, B_RR, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[27] = '{1'b1, 4'hB, A_RR, B_RR, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[28] = '{1'b1, 4'hB, A_RR, B_RR, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[29] = '{1'b0, 4'hB, A_RR, B_RR, 1'b0, 4'h1, 1'b0, 1'b1, 8'h10, 1'b1, 2'd0, 1'b1};
    vecs[30] = '{1'b0, 4'hA, A_RR, B_RR, 1'b1, 4'h2, 1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 1'b0};
    vecs[31] = '{1'b0, 4'h8, A_RR, B_RR, 1'b1, 4'h8, 1'b1, 1'b1, 8'h13, 1'b1, 2'd3, 1'b0};
    vecs[32] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[33] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 34; k++) begin
      do_cycle(vecs[k]);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Continuous contention: grants must rotate 0..3 and the counter must stick at its maximum.
    v = '{1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    do_cycle(v);
    par_lut = 4'b1001;
    for (int i = 0; i < 18; i++) begin
      v.rst  = 1'b0;
      v.vld  = 4'hF;
      v.a    = A_RR;
      v.b    = B_RR;
      v.rdy  = 1'b1;
      v.er   = 4'b0001 << (i % 4);
      v.ev   = (i > 0);
      v.push = 1'b1;
      v.psum = 8'h10 + 8'(i % 4);
      v.ppar = par_lut[i % 4];
      v.pid  = 2'(i % 4);
      v.zero = (i == 0);
      do_cycle(v);
    end
    v = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    do_cycle(v);
    chk("txn_saturated", 32'(txn_count), 32'd15);
    chk("sb_drained_end", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
